// File: rtl/grant_decoder_pkg.sv
// Shared types and default sizing for the grant decoder slice.
package grant_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_e;

  localparam int unsigned DEF_SEL_W    = 3;
  localparam int unsigned DEF_HOLD_MAX = 16;
  localparam int unsigned DEF_CNT_W    = 16;

endpackage

// File: rtl/grant_decoder_if.sv
// Request/grant/ack bundle between the arbiter, the decoder and the serviced units.
interface grant_decoder_if #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned N = 1 << SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_en;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic [SEL_W-1:0] cur_sel;
  logic             done;
  logic             timeout;
  logic             spurious;
  logic [CNT_W-1:0] served;

  modport slave (
    input  in_valid, in_sel, in_en, ack,
    output in_ready, grant, cur_sel, done, timeout, spurious, served
  );

  modport master (
    output in_valid, in_sel, in_en, ack,
    input  in_ready, grant, cur_sel, done, timeout, spurious, served
  );
endinterface

// File: rtl/grant_decoder_onehot_dec.sv
// Combinational index-to-one-hot decoder; all-zero output when disabled.
module onehot_dec #(
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [(1<<SEL_W)-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/grant_decoder.sv
// Registered 3-to-8 grant decoder: holds a one-hot grant until ack or HOLD_MAX
// expiry, then waits for the granted line's ack to drop before re-arming.
module grant_decoder
  import grant_pkg::*;
#(
  parameter int unsigned SEL_W    = DEF_SEL_W,
  parameter int unsigned HOLD_MAX = DEF_HOLD_MAX,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst,
  grant_decoder_if.slave bus
);

  localparam int unsigned N  = 1 << SEL_W;
  localparam int unsigned HW = $clog2(HOLD_MAX);

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] served_q, served_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             spurious_q, spurious_d;

  logic             ready;
  logic [N-1:0]     next_grant;
  logic [N-1:0]     ack_other;
  logic             ack_cur;

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel_i    (bus.in_sel),
    .en_i     (bus.in_en),
    .onehot_o (next_grant)
  );

  assign ready   = (state_q == IDLE) & ~rst;
  assign ack_cur = bus.ack[cur_sel_q];

  always_comb begin
    ack_other            = bus.ack;
    ack_other[cur_sel_q] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cur_sel_d  = cur_sel_q;
    hold_d     = hold_q;
    served_d   = served_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    spurious_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A request with in_en low is consumed but produces no grant.
        if (bus.in_valid && ready && bus.in_en) begin
          cur_sel_d = bus.in_sel;
          grant_d   = next_grant;
          hold_d    = '0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        spurious_d = |ack_other;
        if (ack_cur) begin
          grant_d = '0;
          done_d  = 1'b1;
          if (served_q != '1) served_d = served_q + 1'b1;
          state_d = RELEASE;
        end else if (hold_q == HW'(HOLD_MAX - 1)) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!ack_cur) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      cur_sel_q  <= '0;
      hold_q     <= '0;
      served_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cur_sel_q  <= cur_sel_d;
      hold_q     <= hold_d;
      served_q   <= served_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.grant    = grant_q;
  assign bus.cur_sel  = cur_sel_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
  assign bus.spurious = spurious_q;
  assign bus.served   = served_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Bench for grant_decoder: directed and randomized transactions checked against a
// per-transaction model of grant length, release length and pulses.
module tb_grant_decoder;

  localparam int unsigned HOLD_MAX = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_en = 1'b0;
  logic [2:0] in_sel = '0;
  logic [7:0] ack = '0;

  int checks = 0;
  int errors = 0;
  int served_exp = 0;
  int served_sat_exp = 0;

  always #5 clk = ~clk;

  grant_decoder_if #(.SEL_W(3), .CNT_W(16)) bus ();
  grant_decoder_if #(.SEL_W(3), .CNT_W(2))  bus_s ();

  assign bus.in_valid   = in_valid;
  assign bus.in_en      = in_en;
  assign bus.in_sel     = in_sel;
  assign bus.ack        = ack;
  assign bus_s.in_valid = in_valid;
  assign bus_s.in_en    = in_en;
  assign bus_s.in_sel   = in_sel;
  assign bus_s.ack      = ack;

  grant_decoder #(.SEL_W(3), .HOLD_MAX(HOLD_MAX), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  grant_decoder #(.SEL_W(3), .HOLD_MAX(HOLD_MAX), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input logic [7:0] g, input logic rdy, input logic d,
                          input logic t, input logic s, input logic [2:0] cs);
    chk("grant",      32'(bus.grant),      32'(g));
    chk("grant_sat",  32'(bus_s.grant),    32'(g));
    chk("in_ready",   32'(bus.in_ready),   32'(rdy));
    chk("done",       32'(bus.done),       32'(d));
    chk("timeout",    32'(bus.timeout),    32'(t));
    chk("spurious",   32'(bus.spurious),   32'(s));
    chk("cur_sel",    32'(bus.cur_sel),    32'(cs));
    chk("served",     32'(bus.served),     32'(served_exp));
    chk("served_sat", 32'(bus_s.served),   32'(served_sat_exp));
  endtask

  // a: grant cycle in which ack[sel] rises (<0 or >=HOLD_MAX means never),
  // hold: cycles ack[sel] stays high, noise_c: cycle with an extra ack on noise_line.
  task automatic run_txn(input int sel, input int a, input int hold,
                         input int noise_c, input int noise_line);
    int         len_g;
    int         len_r;
    bit         acked;
    logic [7:0] g;
    acked = (a >= 0) && (a < int'(HOLD_MAX));
    len_g = acked ? a + 1 : int'(HOLD_MAX);
    len_r = acked ? hold : 1;
    g = 8'(1) << sel;
    in_valid = 1'b1;
    in_en    = 1'b1;
    in_sel   = 3'(sel);
    ack      = '0;
    @(posedge clk); #1;
    for (int c = 0; c <= len_g + len_r; c++) begin
      logic [7:0] av;
      av = '0;
      if (acked && c >= a && c < a + hold) av[sel] = 1'b1;
      if (c == noise_c) av[noise_line] = 1'b1;
      ack = av;
      if (c < len_g + len_r) begin
        in_valid = 1'($urandom_range(0, 1));
        in_en    = 1'($urandom_range(0, 1));
        in_sel   = 3'($urandom_range(0, 7));
      end else begin
        in_valid = 1'b0;
      end
      if (c == len_g && acked) begin
        served_exp++;
        if (served_sat_exp < 3) served_sat_exp++;
      end
      @(negedge clk);
      chk_outs(c < len_g ? g : 8'h00, c == len_g + len_r, c == len_g && acked,
               c == len_g && !acked, c >= 1 && (c - 1) < len_g && (c - 1) == noise_c,
               3'(sel));
      @(posedge clk); #1;
    end
    ack = '0;
  endtask

  initial begin
    int sel, a, hold, len_g, noise_c, noise_line;

    // Reset state.
    #1;
    chk_outs(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Null request: consumed, no grant.
    in_valid = 1'b1; in_en = 1'b0; in_sel = 3'd0;
    @(negedge clk);
    chk("null_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_outs(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;

    run_txn(5, 2, 1, -1, 0);            // ack handshake
    run_txn(2, -1, 1, -1, 0);           // timeout after HOLD_MAX cycles
    run_txn(3, 1, 1, 1, 0);             // ack=8'h09: spurious and done together
    run_txn(3, HOLD_MAX - 1, 1, -1, 0); // ack coincides with expiry
    run_txn(7, 0, 6, -1, 0);            // stuck ack keeps RELEASE
    run_txn(1, 0, 1, 1, 6);             // other-line ack during RELEASE ignored

    for (int i = 0; i < 25; i++) begin
      sel  = $urandom_range(0, 7);
      a    = $urandom_range(0, 20);
      if (a >= int'(HOLD_MAX)) a = -1;
      hold = $urandom_range(1, 4);
      len_g = (a >= 0) ? a + 1 : int'(HOLD_MAX);
      noise_c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len_g)) : -1;
      noise_line = (sel + 1 + int'($urandom_range(0, 6))) % 8;
      run_txn(sel, a, hold, noise_c, noise_line);
    end

    // Reset mid-GRANT clears everything asynchronously.
    in_valid = 1'b1; in_en = 1'b1; in_sel = 3'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_grant", 32'(bus.grant), 32'h10);
    #2;
    rst = 1'b1;
    served_exp = 0;
    served_sat_exp = 0;
    #1;
    chk_outs(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_mid_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    run_txn(6, 3, 2, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
